i2s_sample_rx: RTL and testbench
================================

Name: i2s_sample_rx

Overview:
- Upstream stage of the FIR filter. Deserialises one channel of an I2S stream into parallel DWIDTH-bit samples.
- Emits each sample together with a one-cycle sample tick, so its data/tick pair drives the filter's data/sample_tick inputs directly.
- Fully synchronous to the system clock. The external serial pins are oversampled, not used as clocks.

Parameters:
- DWIDTH, 8: output sample width. These are the MSB-first bits captured from each slot.
- SLOT_W, 16: nominal I2S bits per channel slot. Must be ≥ DWIDTH, ≤ 64.
- CHANNEL, 0: captured channel. 0 = left (ws = 0), 1 = right (ws = 1).

Ports:
- clk_i  in  1  system clock. Must be ≥ 4× sck_i frequency.
- rst_i  in  1  asynchronous active-high reset.
- sck_i  in  1  I2S bit clock, asynchronous to clk_i.
- ws_i  in  1  I2S word select, asynchronous.
- sd_i  in  1  I2S serial data, asynchronous.
- data_o  out  DWIDTH  last captured sample, two's complement, MSB-first order preserved.
- sample_tick_o  out  1  one-clk pulse; data_o is valid from this cycle on.
- locked_o  out  1  high once frame alignment is acquired.

Behaviour:
- Decided interface: one clock (clk_i); reset is asynchronous and active-high (rst_i).
- Reset: data_o = 0, sample_tick_o = 0, locked_o = 0, FSM = HUNT, bit counter = 0, sync flops = 0. Reset asserted mid-word discards the partial word; no tick is emitted.
- Input path:
  - sck_i, ws_i and sd_i each pass through a 2-flop synchroniser.
  - A third flop on sck gives rising-edge detection (sck_rise).
  - ws and sd are sampled only on sck_rise.
  - Latency from a pin edge to the internal event is 3 clk.
- Framing (standard I2S): ws changes one bit before the MSB. A ws edge is a sck_rise where the sampled ws differs from the previously sampled ws. On that edge sd carries the LSB of the previous slot and is not captured into the new slot.
- FSM states:
  - HUNT: ignore data. On a ws edge into the CHANNEL polarity -> CAPTURE, counter = 0, locked_o = 1.
  - CAPTURE: on each sck_rise with no ws edge:
    - shift sd into the shift register;
    - increment counter (saturating at SLOT_W);
    - when counter reaches DWIDTH, load data_o and -> EMIT.
  - EMIT (1 clk): sample_tick_o = 1 -> SKIP.
  - SKIP: ignore remaining bits of the slot. On a ws edge into the CHANNEL polarity -> CAPTURE, counter = 0.
- Capture timing: data_o updates in the same clk that sample_tick_o rises, and holds until the next capture.
- Short slot: a ws edge in CAPTURE before DWIDTH bits have been shifted means:
  - remaining LSBs are zero-filled;
  - data_o is loaded and EMIT follows;
  - the new slot is then processed normally: other polarity -> SKIP, otherwise CAPTURE.
- Long slot: bits beyond DWIDTH are ignored. Bits beyond SLOT_W are still ignored and are not an error.
- Simultaneous sck_rise and EMIT cannot occur, given the clk ≥ 4× sck requirement.
- Tick rate: at most one sample_tick_o per I2S frame, i.e. per ws period.

Optional Feature:
- Macro I2S_RX_ERR_CNT_EN.
- Defined:
  - adds port err_cnt_o (out, 8 bits, saturating at 255, reset 0);
  - increments once per short slot, and once per slot longer than SLOT_W bits;
  - adds input err_clr_i (1 bit), which synchronously clears the count; clear wins over a simultaneous increment.
- Undefined: neither port exists. Short and long slots are handled identically, silently.

Decomposition:
- Package i2s_rx_pkg:
  - state enum typedef (HUNT, CAPTURE, EMIT, SKIP);
  - localparam CNT_W = $clog2(SLOT_W + 1);
  - ERR_CNT_W = 8.
- Sub-module: i2s_rx_sync. It holds the three 2-flop synchronisers plus the sck rising-edge detector and is reused by any future I2S TX. The FSM and shifter stay in the top module.

Test Plan:
- DWIDTH = 8, SLOT_W = 16, CHANNEL = 0, left slot MSB-first 0xC5 followed by 8 zeros, right slot 0x3A -> exactly one tick per frame, data_o = 0xC5, right data never appears.
- Same setup with CHANNEL = 1 -> data_o = 0x3A, one tick per frame, tick position within the right slot.
- Left slot shortened to 5 bits 10110 -> data_o = 0xB0, tick issued at the ws edge; with I2S_RX_ERR_CNT_EN, err_cnt_o = 1.
- rst_i pulsed after 3 bits of a slot -> data_o = 0, locked_o = 0, no tick for that slot; first tick from the next full left slot.
- sck_i held static for 1000 clk -> no tick, data_o unchanged. Sixteen consecutive frames 0xC0..0xCF -> sixteen ticks, matching values in order, fed into the filter without loss.

Source files
------------

// File: rtl/i2s_rx_pkg.sv
// Shared types and sizes for the I2S sample receiver.
// Counter width covers the largest supported slot (64 bits).
package i2s_rx_pkg;

  typedef enum logic [1:0] {
    HUNT,
    CAPTURE,
    EMIT,
    SKIP
  } state_t;

  localparam int SLOT_W_MAX = 64;
  localparam int CNT_W      = $clog2(SLOT_W_MAX + 1);
  localparam int ERR_CNT_W  = 8;

endpackage

// File: rtl/i2s_rx_sync.sv
// Pin synchronisers for sck/ws/sd plus sck rising-edge detect.
// Shared by the I2S receive and transmit sides.
module i2s_rx_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sck,
  input  logic i_ws,
  input  logic i_sd,
  output logic o_sck_rise,
  output logic o_ws,
  output logic o_sd
);

  logic r_sck_s1;
  logic r_sck_s2;
  logic r_sck_s3;
  logic r_ws_s1;
  logic r_ws_s2;
  logic r_sd_s1;
  logic r_sd_s2;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sck_s1 <= 1'b0;
      r_sck_s2 <= 1'b0;
      r_sck_s3 <= 1'b0;
      r_ws_s1  <= 1'b0;
      r_ws_s2  <= 1'b0;
      r_sd_s1  <= 1'b0;
      r_sd_s2  <= 1'b0;
    end else begin
      r_sck_s1 <= i_sck;
      r_sck_s2 <= r_sck_s1;
      r_sck_s3 <= r_sck_s2;
      r_ws_s1  <= i_ws;
      r_ws_s2  <= r_ws_s1;
      r_sd_s1  <= i_sd;
      r_sd_s2  <= r_sd_s1;
    end
  end

  assign o_sck_rise = r_sck_s2 & ~r_sck_s3;
  assign o_ws       = r_ws_s2;
  assign o_sd       = r_sd_s2;

endmodule

// File: rtl/i2s_sample_rx.sv
// One-channel I2S deserialiser producing DWIDTH-bit samples plus a tick.
// Define I2S_RX_ERR_CNT_EN to add err_cnt_o / err_clr_i slot error counting.
module i2s_sample_rx
  import i2s_rx_pkg::*;
#(
  parameter int DWIDTH  = 8,
  parameter int SLOT_W  = 16,
  parameter int CHANNEL = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sck_i,
  input  logic              ws_i,
  input  logic              sd_i,
`ifdef I2S_RX_ERR_CNT_EN
  input  logic              err_clr_i,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
`endif
  output logic [DWIDTH-1:0] data_o,
  output logic              sample_tick_o,
  output logic              locked_o
);

  localparam logic             LP_CH   = (CHANNEL != 0);
  localparam logic [CNT_W-1:0] LP_DW   = CNT_W'(DWIDTH);
  localparam logic [CNT_W-1:0] LP_SLOT = CNT_W'(SLOT_W);

  logic              w_sck_rise;
  logic              w_ws;
  logic              w_sd;
  logic              w_ws_edge;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [DWIDTH-1:0] w_shift_nxt;
  logic [DWIDTH-1:0] w_fill;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DWIDTH-1:0] r_shift;
  logic [DWIDTH-1:0] r_data;
  logic              r_tick;
  logic              r_locked;
  logic              r_ws_prev;
  logic              r_primed;

  i2s_rx_sync u_sync (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_sck      (sck_i),
    .i_ws       (ws_i),
    .i_sd       (sd_i),
    .o_sck_rise (w_sck_rise),
    .o_ws       (w_ws),
    .o_sd       (w_sd)
  );

  // First rise after reset only seeds the ws history.
  assign w_ws_edge   = w_sck_rise & r_primed & (w_ws != r_ws_prev);
  assign w_cnt_nxt   = r_cnt + CNT_W'(1);
  assign w_shift_nxt = (r_shift << 1) | DWIDTH'(w_sd);
  assign w_fill      = r_shift << (LP_DW - r_cnt);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= HUNT;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_tick    <= 1'b0;
      r_locked  <= 1'b0;
      r_ws_prev <= 1'b0;
      r_primed  <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (w_sck_rise) begin
        r_ws_prev <= w_ws;
        r_primed  <= 1'b1;
      end
      unique case (r_state)
        HUNT: begin
          if (w_ws_edge && (w_ws == LP_CH)) begin
            r_state  <= CAPTURE;
            r_cnt    <= '0;
            r_locked <= 1'b1;
          end
        end
        CAPTURE: begin
          if (w_ws_edge) begin
            r_data  <= w_fill;
            r_tick  <= 1'b1;
            r_cnt   <= '0;
            r_state <= EMIT;
          end else if (w_sck_rise) begin
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_cnt_nxt == LP_DW) begin
              r_data  <= w_shift_nxt;
              r_tick  <= 1'b1;
              r_state <= EMIT;
            end
          end
        end
        EMIT: begin
          r_state <= SKIP;
        end
        SKIP: begin
          if (w_ws_edge) begin
            r_cnt <= '0;
            if (w_ws == LP_CH) begin
              r_state <= CAPTURE;
            end
          end else if (w_sck_rise && (r_cnt != LP_SLOT)) begin
            r_cnt <= w_cnt_nxt;
          end
        end
        default: r_state <= HUNT;
      endcase
    end
  end

`ifdef I2S_RX_ERR_CNT_EN
  logic                 w_short;
  logic                 w_long;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  // Long slot is judged when the captured channel's slot closes.
  assign w_short = (r_state == CAPTURE) && w_ws_edge;
  assign w_long  = (r_state == SKIP) && w_ws_edge &&
                   (w_ws != LP_CH) && (r_cnt == LP_SLOT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err_cnt <= '0;
    end else if (err_clr_i) begin
      r_err_cnt <= '0;
    end else if ((w_short || w_long) && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end

  assign err_cnt_o = r_err_cnt;
`endif

  assign data_o        = r_data;
  assign sample_tick_o = r_tick;
  assign locked_o      = r_locked;

endmodule

// File: tb/tb_i2s_sample_rx.sv
// Scoreboard bench: left- and right-channel receivers on one I2S stream.
module tb_i2s_sample_rx;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       sck_i = 1'b0;
  logic       ws_i  = 1'b0;
  logic       sd_i  = 1'b0;
  logic [7:0] data0, data1;
  logic       tick0, tick1;
  logic       lock0, lock1;
`ifdef I2S_RX_ERR_CNT_EN
  logic       err_clr_i = 1'b0;
  logic [7:0] err0, err1;
`endif

  int         n_chk  = 0;
  int         n_fail = 0;
  int         ticks0 = 0;
  int         ticks1 = 0;
  int         last_pol = -1;
  logic       cur_pol = 1'b0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] last0 = '0;
  logic [7:0] last1 = '0;

  always #5 clk_i = ~clk_i;

  i2s_sample_rx #(.DWIDTH(8), .SLOT_W(16), .CHANNEL(0)) u_dut_l (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .sck_i         (sck_i),
    .ws_i          (ws_i),
    .sd_i          (sd_i),
`ifdef I2S_RX_ERR_CNT_EN
    .err_clr_i     (err_clr_i),
    .err_cnt_o     (err0),
`endif
    .data_o        (data0),
    .sample_tick_o (tick0),
    .locked_o      (lock0)
  );

  i2s_sample_rx #(.DWIDTH(8), .SLOT_W(16), .CHANNEL(1)) u_dut_r (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .sck_i         (sck_i),
    .ws_i          (ws_i),
    .sd_i          (sd_i),
`ifdef I2S_RX_ERR_CNT_EN
    .err_clr_i     (err_clr_i),
    .err_cnt_o     (err1),
`endif
    .data_o        (data1),
    .sample_tick_o (tick1),
    .locked_o      (lock1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bits on non-edge rises are the slot's first n-1; MSB-first, zero-filled.
  function automatic logic [7:0] exp_val(input logic [63:0] bits,
                                         input int n);
    logic [7:0] v;
    v = '0;
    for (int j = 0; j < 8; j++) begin
      if (j < n - 1) v[7-j] = bits[n-1-j];
    end
    return v;
  endfunction

  task automatic send_bit(input logic ws, input logic sd);
    sck_i = 1'b0;
    ws_i  = ws;
    sd_i  = sd;
    #40;
    sck_i = 1'b1;
    #40;
  endtask

  task automatic send_slot(input logic pol, input logic [63:0] bits,
                           input int n, input logic nxt);
    cur_pol = pol;
    if (last_pol == int'(!pol)) begin
      if (pol) q1.push_back(exp_val(bits, n));
      else     q0.push_back(exp_val(bits, n));
    end
    last_pol = int'(pol);
    for (int i = 0; i < n; i++) begin
      send_bit((i == n - 1) ? nxt : pol, bits[n-1-i]);
    end
  endtask

  task automatic send_frame(input logic [63:0] lb, input int ln,
                            input logic [63:0] rb, input int rn);
    send_slot(1'b0, lb, ln, 1'b1);
    send_slot(1'b1, rb, rn, 1'b0);
  endtask

  always @(negedge clk_i) begin
    if (!rst_i && tick0) begin
      ticks0++;
      if (q0.size() == 0) begin
        chk("ch0_unexpected_tick", {24'd0, data0}, 32'hFFFF_FFFF);
      end else begin
        last0 = q0.pop_front();
        chk("ch0_data", {24'd0, data0}, {24'd0, last0});
      end
    end
    if (!rst_i && tick1) begin
      ticks1++;
      chk("ch1_tick_in_right_slot", {31'd0, cur_pol}, 32'd1);
      if (q1.size() == 0) begin
        chk("ch1_unexpected_tick", {24'd0, data1}, 32'hFFFF_FFFF);
      end else begin
        last1 = q1.pop_front();
        chk("ch1_data", {24'd0, data1}, {24'd0, last1});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    logic [15:0] rnd;
    #23;
    chk("rst_data0", {24'd0, data0}, 32'd0);
    chk("rst_tick0", {31'd0, tick0}, 32'd0);
    chk("rst_lock0", {31'd0, lock0}, 32'd0);
    chk("rst_data1", {24'd0, data1}, 32'd0);
    chk("rst_tick1", {31'd0, tick1}, 32'd0);
    chk("rst_lock1", {31'd0, lock1}, 32'd0);
    rst_i = 1'b0;
    #20;

    repeat (3) send_frame(64'hC500, 16, 64'h3A00, 16);
    chk("locked0", {31'd0, lock0}, 32'd1);
    chk("locked1", {31'd0, lock1}, 32'd1);
    chk("ticks0_3frames", ticks0, 32'd2);
    chk("ticks1_3frames", ticks1, 32'd3);

    send_frame(64'b10110, 5, 64'h3A00, 16);
    chk("short_data0", {24'd0, data0}, 32'hB0);
`ifdef I2S_RX_ERR_CNT_EN
    chk("short_err0", {24'd0, err0}, 32'd1);
    chk("short_err1", {24'd0, err1}, 32'd0);
    err_clr_i = 1'b1;
    #10;
    err_clr_i = 1'b0;
    #10;
    chk("err0_cleared", {24'd0, err0}, 32'd0);
`endif
    send_frame(64'hC500, 16, 64'h3A00, 16);

    cur_pol = 1'b0;
    repeat (3) send_bit(1'b0, 1'b1);
    rst_i = 1'b1;
    #20;
    chk("midrst_data0", {24'd0, data0}, 32'd0);
    chk("midrst_lock0", {31'd0, lock0}, 32'd0);
    chk("midrst_tick0", {31'd0, tick0}, 32'd0);
    chk("midrst_data1", {24'd0, data1}, 32'd0);
    chk("midrst_lock1", {31'd0, lock1}, 32'd0);
    rst_i = 1'b0;
    last_pol = -1;
    last0 = '0;
    last1 = '0;
    t0 = ticks0;
    send_slot(1'b0, 64'h1FFF, 13, 1'b1);
    send_slot(1'b1, 64'h5A00, 16, 1'b0);
    chk("no_tick0_after_rst", ticks0 - t0, 32'd0);
    repeat (2) send_frame(64'h9600, 16, 64'h3A00, 16);
    chk("ticks0_after_rst", ticks0 - t0, 32'd2);

    t0 = ticks0 + ticks1;
    #10000;
    chk("static_no_tick", ticks0 + ticks1 - t0, 32'd0);
    chk("static_data0", {24'd0, data0}, {24'd0, last0});
    chk("static_data1", {24'd0, data1}, {24'd0, last1});

    t0 = ticks0;
    for (int i = 0; i < 16; i++) begin
      rnd = 16'($urandom_range(0, 65535));
      send_frame({48'd0, 8'hC0 + 8'(i), 8'h00}, 16, {48'd0, rnd}, 16);
    end
    chk("burst_ticks0", ticks0 - t0, 32'd16);

    #200;
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
